// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared types and constants for the program loader.
// CHECK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

    localparam int LOADER_DATA_W = 2;
    localparam int LOADER_ADDR_W = 2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_COMMIT,
        S_RUN,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: streams program words into CPU memory, holds the CPU in reset until loaded.
// Optional trailing checksum word: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W = LOADER_DATA_W,
    parameter int ADDR_W = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);

    localparam int DEPTH = 2**ADDR_W;

    loader_state_t state, state_nxt;
    logic [ADDR_W:0] cnt;
    logic            accept, wr, last, start;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LOAD = S_CHECK;
    logic [DATA_W-1:0] sum;
    logic              match;
    assign in_ready = state == S_LOAD || state == S_CHECK;
    assign busy     = state == S_LOAD || state == S_CHECK || state == S_COMMIT;
    assign error    = state == S_ERROR;
`else
    localparam loader_state_t AFTER_LOAD = S_COMMIT;
    assign in_ready = state == S_LOAD;
    assign busy     = state == S_LOAD || state == S_COMMIT;
    assign error    = 1'b0;
`endif

    assign accept  = in_valid && in_ready;
    assign wr      = accept && state == S_LOAD;
    assign last    = cnt == (ADDR_W+1)'(DEPTH-1);
    assign start   = state != S_LOAD && state_nxt == S_LOAD;
    assign cpu_run = state == S_RUN;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN, S_ERROR: state_nxt = load_start ? S_LOAD : state;
            S_LOAD:                 state_nxt = wr && last ? AFTER_LOAD : state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK:                state_nxt = accept ? S_COMMIT : state;
            S_COMMIT:               state_nxt = match ? S_RUN : S_ERROR;
`else
            S_COMMIT:               state_nxt = S_RUN;
`endif
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= start ? '0 : cnt + (ADDR_W+1)'(wr);
            mem_we <= wr;
            if (wr) begin
                mem_addr  <= cnt[ADDR_W-1:0];
                mem_wdata <= in_data;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // sum already holds every data word by the time the checksum word arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum   <= '0;
            match <= 1'b0;
        end else begin
            sum   <= start ? '0 : wr ? sum + in_data : sum;
            match <= state == S_CHECK && accept ? in_data == sum : match;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized directed-sequence bench for program_loader.
// Builds with or without PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int DW    = LOADER_DATA_W;
    localparam int AW    = LOADER_ADDR_W;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0, rst = 1'b0, load_start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, mem_we, cpu_run, busy, error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] prog [DEPTH];
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    program_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_error"}, 32'(error), 0);
    endtask

    task automatic fill_random;
        for (int k = 0; k < DEPTH; k++) prog[k] = DW'($urandom_range(0, 2**DW - 1));
    endtask

    task automatic start_load;
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk);
    endtask

    // Stream n words; the write model is "word i accepted at an edge appears at address i next cycle".
    task automatic stream(input int n, input bit bubbles, input bit poke);
        int i = 0, cyc = 0, last = 0;
        bit acc = 1'b0;
        while (i < n && cyc < 100) begin
            @(negedge clk);
            check("load_we", 32'(mem_we), 32'(acc));
            if (acc) begin
                check("load_addr", 32'(mem_addr), 32'(last));
                check("load_data", 32'(mem_wdata), 32'(prog[last]));
            end
            check("load_ready", 32'(in_ready), 1);
            check("load_busy", 32'(busy), 1);
            check("load_run", 32'(cpu_run), 0);
            check("load_error", 32'(error), 0);
            in_valid   = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data    = in_valid ? prog[i] : DW'($urandom);
            load_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            acc  = in_valid;
            last = i;
            if (in_valid) i++;
            cyc++;
        end
        if (i < n) check("stream_timeout", 32'(i), 32'(n));
        if (n == DEPTH) begin
            @(negedge clk);
            load_start = 1'b0;
            in_valid   = 1'b0;
            check("last_we", 32'(mem_we), 1);
            check("last_addr", 32'(mem_addr), 32'(DEPTH - 1));
            check("last_data", 32'(mem_wdata), 32'(prog[DEPTH-1]));
        end
    endtask

    // Called at the negedge following the final data accept.
    task automatic finish_load(input bit corrupt);
        int s = 0;
        for (int k = 0; k < DEPTH; k++) s += int'(prog[k]);
        s = s % (2**DW);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("check_ready", 32'(in_ready), 1);
        check("check_busy", 32'(busy), 1);
        in_valid = 1'b1;
        in_data  = DW'(s + (corrupt ? 1 : 0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("csum_no_write", 32'(mem_we), 0);
        check("commit_busy", 32'(busy), 1);
        check("commit_ready", 32'(in_ready), 0);
        check("commit_run", 32'(cpu_run), 0);
        @(negedge clk);
        check("done_run", 32'(cpu_run), 32'(!corrupt));
        check("done_error", 32'(error), 32'(corrupt));
        check("done_busy", 32'(busy), 0);
`else
        check("commit_busy", 32'(busy), 1);
        check("commit_ready", 32'(in_ready), 0);
        check("commit_run", 32'(cpu_run), 0);
        @(negedge clk);
        check("done_run", 32'(cpu_run), 1);
        check("done_busy", 32'(busy), 0);
        check("done_we", 32'(mem_we), 0);
        check("done_error", 32'(error), 0);
`endif
    endtask

    initial begin
        #12;
        all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("idle_ready", 32'(in_ready), 0);
            check("idle_we", 32'(mem_we), 0);
            check("idle_busy", 32'(busy), 0);
        end
        for (int k = 0; k < DEPTH; k++) prog[k] = k == 0 ? OP_NOP : k == DEPTH - 1 ? DW'(2) : OP_ADD;
        start_load;
        stream(DEPTH, 1'b0, 1'b0);
        finish_load(1'b0);
        // reloads straight out of RUN, with bubbles and ignored load_start pulses
        repeat (4) begin
            fill_random;
            start_load;
            stream(DEPTH, 1'b1, 1'b1);
            finish_load(1'b0);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        fill_random;
        start_load;
        stream(DEPTH, 1'b1, 1'b0);
        finish_load(1'b1);
        @(negedge clk);
        check("err_hold", 32'(error), 1);
        check("err_run", 32'(cpu_run), 0);
        check("err_ready", 32'(in_ready), 0);
        fill_random;
        start_load;
        stream(DEPTH, 1'b0, 1'b1);
        finish_load(1'b0);
`endif
        fill_random;
        start_load;
        stream(2, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 all_zero("async_reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("post_rst_ready", 32'(in_ready), 0);
            check("post_rst_run", 32'(cpu_run), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        fill_random;
        start_load;
        stream(DEPTH, 1'b1, 1'b0);
        finish_load(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
